// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor
// Receive-side checker for the one-hot lamp code of a cyclic lamp controller.
// Locks onto the GREEN -> YELLOW -> RED -> GREEN sequence, counts completed
// cycles and dwell time, and latches a sticky fault on illegal codes,
// out-of-order transitions or a stuck lamp.
// Optional build macro LAMP_MON_FAULT_CNT_EN adds a saturating fault_count
// output that counts entries into the fault state.
module lamp_sequence_monitor #(
  parameter int MAX_DWELL = 15,
  parameter int DWELL_W   = 8,
  parameter int CNT_W     = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [0:2]         light,
  input  logic               clear_fault,
  output logic [1:0]         color,
  output logic               synced,
  output logic               fault,
  output logic [1:0]         fault_code,
  output logic [CNT_W-1:0]   cycle_count,
`ifdef LAMP_MON_FAULT_CNT_EN
  output logic [7:0]         fault_count,
`endif
  output logic [DWELL_W-1:0] dwell
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SYNC   = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    COL_NONE   = 2'd0,
    COL_GREEN  = 2'd1,
    COL_YELLOW = 2'd2,
    COL_RED    = 2'd3
  } colour_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ILLEGAL = 2'd1,
    FC_ORDER   = 2'd2,
    FC_STUCK   = 2'd3
  } fcode_t;

  localparam logic [DWELL_W-1:0] DWELL_LIMIT = DWELL_W'(MAX_DWELL);
  localparam logic [DWELL_W-1:0] DWELL_ONE   = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  // Exactly-one-hot codes decode to a colour; anything else (including
  // all-zero, multi-hot and unknown bits) decodes to COL_NONE.
  function automatic colour_t decode_light(input logic [0:2] code);
    colour_t c;
    case (code)
      3'b100:  c = COL_RED;
      3'b010:  c = COL_GREEN;
      3'b001:  c = COL_YELLOW;
      default: c = COL_NONE;
    endcase
    return c;
  endfunction

  // The only colour allowed to follow a given colour in the lamp cycle.
  function automatic colour_t successor(input colour_t c);
    colour_t s;
    case (c)
      COL_GREEN:  s = COL_YELLOW;
      COL_YELLOW: s = COL_RED;
      COL_RED:    s = COL_GREEN;
      default:    s = COL_NONE;
    endcase
    return s;
  endfunction

  state_t             state_q, state_d;
  colour_t            prev_q, prev_d;
  colour_t            color_q, color_d;
  logic               synced_q, synced_d;
  logic               fault_q, fault_d;
  fcode_t             fcode_q, fcode_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               enter_fault;
  colour_t            sample;

  assign sample = decode_light(light);

  // Next-state and next-output logic for the lock / track / fault machine.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    color_d     = color_q;
    synced_d    = synced_q;
    fault_d     = fault_q;
    fcode_d     = fcode_q;
    cycle_d     = cycle_q;
    dwell_d     = dwell_q;
    enter_fault = 1'b0;

    case (state_q)
      ST_UNSYNC: begin
        // Illegal codes are ignored until the first clean colour arrives;
        // locking does not count as a completed cycle.
        if (sample != COL_NONE) begin
          state_d  = ST_SYNC;
          prev_d   = sample;
          color_d  = sample;
          synced_d = 1'b1;
          dwell_d  = DWELL_ONE;
        end
      end

      ST_SYNC: begin
        if (sample == COL_NONE) begin
          enter_fault = 1'b1;
          fcode_d     = FC_ILLEGAL;
        end else if (sample == prev_q) begin
          // Dwell freezes at the limit when the stuck fault fires.
          if (dwell_q == DWELL_LIMIT) begin
            enter_fault = 1'b1;
            fcode_d     = FC_STUCK;
          end else begin
            dwell_d = dwell_q + DWELL_ONE;
          end
        end else if (sample == successor(prev_q)) begin
          prev_d  = sample;
          color_d = sample;
          dwell_d = DWELL_ONE;
          if (prev_q == COL_RED) begin
            cycle_d = cycle_q + CNT_ONE;
          end
        end else begin
          enter_fault = 1'b1;
          fcode_d     = FC_ORDER;
        end

        if (enter_fault) begin
          state_d  = ST_FAULT;
          fault_d  = 1'b1;
          synced_d = 1'b0;
          color_d  = COL_NONE;
        end
      end

      ST_FAULT: begin
        // Only clear_fault leaves the fault state; the cycle count survives
        // so a diagnostic host can still read how far the controller got.
        if (clear_fault) begin
          state_d  = ST_UNSYNC;
          fault_d  = 1'b0;
          fcode_d  = FC_NONE;
          dwell_d  = '0;
          prev_d   = COL_NONE;
          color_d  = COL_NONE;
          synced_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_UNSYNC;
      end
    endcase
  end

  // State and output registers; reset wins over every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_UNSYNC;
      prev_q   <= COL_NONE;
      color_q  <= COL_NONE;
      synced_q <= 1'b0;
      fault_q  <= 1'b0;
      fcode_q  <= FC_NONE;
      cycle_q  <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      color_q  <= color_d;
      synced_q <= synced_d;
      fault_q  <= fault_d;
      fcode_q  <= fcode_d;
      cycle_q  <= cycle_d;
      dwell_q  <= dwell_d;
    end
  end

`ifdef LAMP_MON_FAULT_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;

  // Saturating count of fault entries; clear_fault does not touch it.
  always_comb begin
    fcnt_d = fcnt_q;
    if (enter_fault && (fcnt_q != 8'hFF)) begin
      fcnt_d = fcnt_q + 8'd1;
    end
  end

  // Fault counter register, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign fault_count = fcnt_q;
`endif

  assign color       = color_q;
  assign synced      = synced_q;
  assign fault       = fault_q;
  assign fault_code  = fcode_q;
  assign cycle_count = cycle_q;
  assign dwell       = dwell_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Scoreboard bench for lamp_sequence_monitor. A second instance with a
// 2-bit cycle counter runs on the same stimulus to exercise counter wrap.
`timescale 1ns/1ps
module tb_lamp_sequence_monitor;

  localparam logic [0:2] G = 3'b010;
  localparam logic [0:2] Y = 3'b001;
  localparam logic [0:2] R = 3'b100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [0:2] light = 3'b000;
  logic       clear_fault = 1'b0;

  logic [1:0] color, color2;
  logic       synced, synced2, fault, fault2;
  logic [1:0] fault_code, fault_code2;
  logic [7:0] cycle_count;
  logic [1:0] cycle_count2;
  logic [7:0] dwell, dwell2;
`ifdef LAMP_MON_FAULT_CNT_EN
  logic [7:0] fault_count, fault_count2;
`endif

  lamp_sequence_monitor dut (
    .clock(clock), .reset(reset), .light(light), .clear_fault(clear_fault),
    .color(color), .synced(synced), .fault(fault), .fault_code(fault_code),
    .cycle_count(cycle_count),
`ifdef LAMP_MON_FAULT_CNT_EN
    .fault_count(fault_count),
`endif
    .dwell(dwell)
  );

  lamp_sequence_monitor #(.CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .light(light), .clear_fault(clear_fault),
    .color(color2), .synced(synced2), .fault(fault2), .fault_code(fault_code2),
    .cycle_count(cycle_count2),
`ifdef LAMP_MON_FAULT_CNT_EN
    .fault_count(fault_count2),
`endif
    .dwell(dwell2)
  );

  always #5 clock = ~clock;

  typedef struct {
    int step;
    int color;
    int synced;
    int fault;
    int code;
    int cnt;
    int dwell;
    int fc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;
  int   fc_model = 0;
  int   last_fault = 0;

  task automatic chk(input int step, input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL step %0d %s: got %0d, expected %0d", step, name, act, exp);
    end
  endtask

  // Drive one sample and queue the hand-computed outputs after the next edge.
  task automatic step(input logic [0:2] l, input logic clr, input logic rst,
                      input int e_color, input int e_synced, input int e_fault,
                      input int e_code, input int e_cnt, input int e_dwell);
    exp_t e;
    @(negedge clock);
    light       = l;
    clear_fault = clr;
    reset       = rst;
    if (rst) fc_model = 0;
    else if (e_fault == 1 && last_fault == 0 && fc_model < 255) fc_model++;
    last_fault = rst ? 0 : e_fault;
    step_no++;
    e.step = step_no; e.color = e_color; e.synced = e_synced; e.fault = e_fault;
    e.code = e_code; e.cnt = e_cnt; e.dwell = e_dwell; e.fc = fc_model;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces a registered sample to check.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.step, "color",       int'(color),       e.color);
      chk(e.step, "synced",      int'(synced),      e.synced);
      chk(e.step, "fault",       int'(fault),       e.fault);
      chk(e.step, "fault_code",  int'(fault_code),  e.code);
      chk(e.step, "cycle_count", int'(cycle_count), e.cnt);
      chk(e.step, "dwell",       int'(dwell),       e.dwell);
      chk(e.step, "cnt_w2",      int'(cycle_count2), e.cnt % 4);
      chk(e.step, "fault_w2",    int'(fault2),      e.fault);
`ifdef LAMP_MON_FAULT_CNT_EN
      chk(e.step, "fault_count", int'(fault_count), e.fc);
`endif
    end
  end

  initial begin
    int wait_cyc;
    // Reset, then clean sequence G Y R G Y R G Y R.
    step(3'b000, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    step(3'b000, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1);
    step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 0, 1);
    step(R, 1'b0, 1'b0, 3, 1, 0, 0, 0, 1);
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 1, 1);
    step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 1, 1);
    step(R, 1'b0, 1'b0, 3, 1, 0, 0, 1, 1);
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 2, 1);
    step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 2, 1);
    step(R, 1'b0, 1'b0, 3, 1, 0, 0, 2, 1);
    // G then R: bad transition; inputs ignored while faulted.
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 3, 1);
    step(R, 1'b0, 1'b0, 0, 0, 1, 2, 3, 1);
    step(Y, 1'b0, 1'b0, 0, 0, 1, 2, 3, 1);
    step(G, 1'b0, 1'b0, 0, 0, 1, 2, 3, 1);
    step(G, 1'b1, 1'b0, 0, 0, 0, 0, 3, 0);
    // Relock, illegal 110, hold, clear, relock (clear ignored when synced).
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 3, 1);
    step(3'b110, 1'b0, 1'b0, 0, 0, 1, 1, 3, 1);
    step(3'b110, 1'b0, 1'b0, 0, 0, 1, 1, 3, 1);
    step(G, 1'b0, 1'b0, 0, 0, 1, 1, 3, 1);
    step(Y, 1'b0, 1'b0, 0, 0, 1, 1, 3, 1);
    step(3'b000, 1'b1, 1'b0, 0, 0, 0, 0, 3, 0);
    step(G, 1'b1, 1'b0, 1, 1, 0, 0, 3, 1);
    step(G, 1'b1, 1'b0, 1, 1, 0, 0, 3, 2);
    // Stuck yellow: dwell 1..15, 16th sample faults and dwell stays 15.
    step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 3, 1);
    for (int i = 2; i <= 15; i++) step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 3, i);
    step(Y, 1'b0, 1'b0, 0, 0, 1, 3, 3, 15);
    step(Y, 1'b0, 1'b0, 0, 0, 1, 3, 3, 15);
    // Reset with clear_fault asserted, then illegal codes ignored while unsynced.
    step(G, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
    step(3'b000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    step(3'b111, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    step(3'b011, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    step(R, 1'b0, 1'b0, 3, 1, 0, 0, 0, 1);
    // Lock on RED counts the following R->G; run to cycle_count=5.
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 1, 1);
    for (int c = 2; c <= 5; c++) begin
      step(Y, 1'b0, 1'b0, 2, 1, 0, 0, c - 1, 1);
      step(R, 1'b0, 1'b0, 3, 1, 0, 0, c - 1, 1);
      step(G, 1'b0, 1'b0, 1, 1, 0, 0, c, 1);
    end
    // Y->G is out of order; then reset with clear_fault clears everything.
    step(Y, 1'b0, 1'b0, 2, 1, 0, 0, 5, 1);
    step(G, 1'b0, 1'b0, 0, 0, 1, 2, 5, 1);
    step(G, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
    // R->Y out of order from a fresh lock, then mid-operation reset.
    step(R, 1'b0, 1'b0, 3, 1, 0, 0, 0, 1);
    step(Y, 1'b0, 1'b0, 0, 0, 1, 2, 0, 1);
    step(G, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1);
    step(G, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    step(G, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1);

    @(negedge clock);
    reset = 1'b0;
    clear_fault = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clock);
      wait_cyc++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
